// File: rtl/scs8hd_orn_pkg.sv
// rtl/scs8hd_orn_pkg.sv - shared types and parameter helpers for the filtered N-input OR
package scs8hd_orn_pkg;

  // Qualifier states: settled low, qualifying a rise, settled high, qualifying a fall
  typedef enum logic [1:0] {
    LO      = 2'd0,
    QUAL_HI = 2'd1,
    HI      = 2'd2,
    QUAL_LO = 2'd3
  } orn_state_e;

  localparam int FILT_CYC_MIN = 1;
  localparam int FILT_CYC_MAX = 255;

  // Pull an out-of-range filter length back into the supported 1..255 window
  function automatic int filt_cyc_legal(input int f);
    if (f < FILT_CYC_MIN) return FILT_CYC_MIN;
    if (f > FILT_CYC_MAX) return FILT_CYC_MAX;
    return f;
  endfunction

endpackage

// File: rtl/scs8hd_orn_qual.sv
// rtl/scs8hd_orn_qual.sv - glitch qualifier FSM with sticky capture and edge pulses
module scs8hd_orn_qual
  import scs8hd_orn_pkg::*;
#(
  parameter int FILT_CYC = 2,
  parameter int CNT_W    = $clog2(FILT_CYC + 1)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic S,
  input  logic STICKY,
  input  logic CLR,
  output logic X,
  output logic XRISE,
  output logic XFALL
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  orn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             xrise_q, xrise_d;
  logic             xfall_q, xfall_d;

  // Next-state: count consecutive disagreeing samples, flip X once FILT_CYC agree
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    xrise_d = 1'b0;
    xfall_d = 1'b0;
    if (CLR) begin
      // Clear wins over any qualification landing on the same edge
      state_d = LO;
      cnt_d   = '0;
      x_d     = 1'b0;
      xfall_d = x_q;
    end else begin
      unique case (state_q)
        LO: begin
          if (S) begin
            if (FILT_CYC == 1) begin
              state_d = HI;
              x_d     = 1'b1;
              xrise_d = 1'b1;
            end else begin
              state_d = QUAL_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        QUAL_HI: begin
          if (!S) begin
            state_d = LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HI;
            cnt_d   = '0;
            x_d     = 1'b1;
            xrise_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HI: begin
          // Sticky mode pins X high until an explicit clear
          if (!S && !STICKY) begin
            if (FILT_CYC == 1) begin
              state_d = LO;
              x_d     = 1'b0;
              xfall_d = 1'b1;
            end else begin
              state_d = QUAL_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        QUAL_LO: begin
          if (S || STICKY) begin
            state_d = HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LO;
            cnt_d   = '0;
            x_d     = 1'b0;
            xfall_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = LO;
          cnt_d   = '0;
          x_d     = 1'b0;
        end
      endcase
    end
  end

  // State, counter, output and pulse registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= LO;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      xrise_q <= 1'b0;
      xfall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xrise_q <= xrise_d;
      xfall_q <= xfall_d;
    end
  end

  assign X     = x_q;
  assign XRISE = xrise_q;
  assign XFALL = xfall_q;

endmodule

// File: rtl/scs8hd_orn_filt.sv
// rtl/scs8hd_orn_filt.sv - N-input OR with polarity mask, sampled and glitch-qualified
module scs8hd_orn_filt
  import scs8hd_orn_pkg::*;
#(
  parameter int           N        = 4,
  parameter logic [N-1:0] INV_MASK = N'(4'b1000),
  parameter int           FILT_CYC = 2,
  parameter int           CNT_W    = $clog2(FILT_CYC + 1)
) (
`ifdef SC_USE_PG_PIN
  input  logic         vpwr,
  input  logic         vgnd,
  input  logic         vpb,
  input  logic         vnb,
`endif
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] A,
  input  logic         STICKY,
  input  logic         CLR,
  output logic         X,
  output logic         XRISE,
  output logic         XFALL
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  localparam int FILT_EFF = filt_cyc_legal(FILT_CYC);
  localparam int QCNT_W   = (CNT_W < 1) ? 1 : CNT_W;

  logic s_q, s_d;
  logic x_int;

  // Apply the per-input polarity and reduce to a single OR term
  always_comb begin
    s_d = |(A ^ INV_MASK);
  end

  // Single sampling register; A is already in the CLK domain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s_d;
    end
  end

  scs8hd_orn_qual #(
    .FILT_CYC (FILT_EFF),
    .CNT_W    (QCNT_W)
  ) u_qual (
    .CLK    (CLK),
    .RESET  (RESET),
    .S      (s_q),
    .STICKY (STICKY),
    .CLR    (CLR),
    .X      (x_int),
    .XRISE  (XRISE),
    .XFALL  (XFALL)
  );

`ifdef SC_USE_PG_PIN
  scs8hd_pg_U_VPWR_VGND u_pg_x (X, x_int, vpwr, vgnd);
`else
  assign X = x_int & vpwr & vpb & ~vgnd & ~vnb;
`endif

endmodule

// File: tb/tb_scs8hd_orn_filt.sv
// tb/tb_scs8hd_orn_filt.sv - randomized scoreboard bench for the filtered N-input OR
module tb_scs8hd_orn_filt;

  logic       clk = 1'b0;
  logic       rst, sticky, clr;
  logic [3:0] a4;
  logic [7:0] a8;
  logic       x0, r0, f0, x1, r1, f1;

  scs8hd_orn_filt dut0 (
    .CLK(clk), .RESET(rst), .A(a4), .STICKY(sticky), .CLR(clr),
    .X(x0), .XRISE(r0), .XFALL(f0)
  );

  scs8hd_orn_filt #(.N(8), .INV_MASK(8'hFF), .FILT_CYC(1)) dut1 (
    .CLK(clk), .RESET(rst), .A(a8), .STICKY(sticky), .CLR(clr),
    .X(x1), .XRISE(r1), .XFALL(f1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x0, r0, f0, x1, r1, f1;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   errors  = 0;

  // Reference: S sample, X, and a count of consecutive samples disagreeing with X
  logic m_s[2];
  logic m_x[2];
  int   m_run[2];
  int   filt[2] = '{2, 1};

  task automatic model_step(input int k, input logic s_new, input logic stk,
                            input logic cl, input logic rs,
                            output logic xo, output logic ro, output logic fo);
    logic x_prev;
    x_prev = m_x[k];
    ro = 1'b0;
    fo = 1'b0;
    if (rs) begin
      m_s[k] = 1'b0; m_x[k] = 1'b0; m_run[k] = 0;
    end else if (cl) begin
      fo = x_prev; m_x[k] = 1'b0; m_run[k] = 0; m_s[k] = s_new;
    end else begin
      if (m_s[k] != m_x[k] && !(m_x[k] && stk)) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == filt[k]) begin
          m_x[k] = m_s[k];
          m_run[k] = 0;
          ro = m_x[k];
          fo = !m_x[k];
        end
      end else begin
        m_run[k] = 0;
      end
      m_s[k] = s_new;
    end
    xo = m_x[k];
  endtask

  task automatic apply(input logic [3:0] va4, input logic [7:0] va8,
                       input logic vst, input logic vcl, input logic vrs);
    exp_t ex;
    a4 = va4; a8 = va8; sticky = vst; clr = vcl; rst = vrs;
    model_step(0, ((va4 ^ 4'b1000) != 4'd0), vst, vcl, vrs, ex.x0, ex.r0, ex.f0);
    model_step(1, ((va8 ^ 8'hFF) != 8'd0), vst, vcl, vrs, ex.x1, ex.r1, ex.f1);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
    end
  endtask

  // Monitor: every edge produces one output set; compare it against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x_n4",     x0, e.x0);
        chk("xrise_n4", r0, e.r0);
        chk("xfall_n4", f0, e.f0);
        chk("x_n8",     x1, e.x1);
        chk("xrise_n8", r1, e.r1);
        chk("xfall_n8", f1, e.f1);
      end
    end
  end

  logic [3:0] ra4;
  logic [7:0] ra8;
  logic       rstk;

  initial begin
    m_s = '{1'b0, 1'b0};
    m_x = '{1'b0, 1'b0};
    m_run = '{0, 0};

    repeat (2) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (10) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (5) apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    // single-cycle glitch
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    // sticky capture then clear
    repeat (5) apply(4'b0001, 8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (20) apply(4'b1000, 8'hFF, 1'b1, 1'b0, 1'b0);
    apply(4'b1000, 8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (3) apply(4'b1000, 8'hFF, 1'b1, 1'b0, 1'b0);
    // clear on the qualifying edge, then re-qualify with S held
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    apply(4'b0001, 8'hFF, 1'b0, 1'b1, 1'b0);
    repeat (4) apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    // reset while qualifying
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (4) apply(4'b0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (4) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    // inverted 8-input instance: all-ones is idle, one low bit asserts
    repeat (4) apply(4'b1000, 8'hFE, 1'b0, 1'b0, 1'b0);
    repeat (3) apply(4'b1000, 8'hFF, 1'b0, 1'b0, 1'b0);
    // reset and clear together
    apply(4'b0001, 8'h00, 1'b0, 1'b1, 1'b1);
    repeat (4) apply(4'b0001, 8'h00, 1'b0, 1'b0, 1'b0);

    ra4 = 4'b1000;
    ra8 = 8'hFF;
    rstk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ra4 = ($urandom_range(1) == 1) ? 4'b1000 : 4'($urandom);
      if ($urandom_range(3) == 0) ra8 = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom);
      if ($urandom_range(39) == 0) rstk = ~rstk;
      apply(ra4, ra8, rstk, ($urandom_range(29) == 0), ($urandom_range(149) == 0));
    end

    @(posedge clk);
    #4;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
